// File: rtl/write_port_arbiter.sv
// write_port_arbiter: 4-way round-robin write-port arbiter with optional locked hold (enable with `define WRITE_PORT_ARBITER_LOCK_EN)
module write_port_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic [3:0] lock,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       grant_valid,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
   state_t     state;
   logic [1:0] ptr;
   logic [3:0] cnt;
   logic [1:0] base;
   logic [1:0] win;
   logic [1:0] c;
   logic       found;
   logic       hold_ok;
   // search from ptr when idle, or from just past the owner when its grant is ending
   always_comb begin
      base = (state == IDLE) ? ptr : grant_idx + 2'd1;
      win = 2'd0;
      found = 1'b0;
      c = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         c = base + k[1:0];
         if (req[c]) begin
            win = c;
            found = 1'b1;
         end
      end
   end
`ifdef WRITE_PORT_ARBITER_LOCK_EN
   assign hold_ok = (state != IDLE) && req[grant_idx] && lock[grant_idx] && (cnt < 4'(MAX_HOLD));
   assign busy = (state == HOLD);
`else
   logic unused_lock;
   assign unused_lock = ^lock;
   assign hold_ok = 1'b0;
   assign busy = 1'b0;
`endif
   // state, pointer, hold counter and registered grant outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ptr <= 2'd0;
         cnt <= 4'd0;
         grant <= 4'd0;
         grant_idx <= 2'd0;
         grant_valid <= 1'b0;
      end else if (hold_ok) begin
         state <= HOLD;
         cnt <= cnt + 4'd1;
      end else begin
         if (state != IDLE) ptr <= grant_idx + 2'd1;
         state <= found ? GRANT : IDLE;
         cnt <= found ? 4'd1 : 4'd0;
         grant <= found ? 4'b0001 << win : 4'd0;
         grant_idx <= found ? win : 2'd0;
         grant_valid <= found;
      end
   end
endmodule
